// File: rtl/mio_bus_ctrl.sv
// mio_bus_ctrl: memory-mapped I/O bus controller between the CPU data port
// and up to NSLV peripheral slaves. Address bits [31:28] select either the
// internal control region (display mode / bus-error capture) or a slave
// region. Slave accesses run IDLE -> ACCESS (1+W cycles) -> RESP. Control
// and unmapped accesses go IDLE -> RESP directly. Every output is a register.
module mio_bus_ctrl #(
   parameter int                NSLV        = 8,
   parameter int                DW          = 32,
   parameter int                RAM_AW      = 13,
   parameter logic [NSLV*4-1:0] REGION_MAP  = {4'h0, 4'he, 4'hf, 4'hd, 4'hc, 4'h0, 4'h0, 4'h0},
   parameter logic [NSLV-1:0]   SLV_EN      = 8'b0001_1111,
   parameter logic [NSLV*3-1:0] SLV_WAIT    = {(NSLV*3){1'b0}},
   parameter logic [3:0]        CTRL_REGION = 4'hb
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               mem_req,
   input  logic               mem_w,
   input  logic [31:0]        addr_bus,
   input  logic [DW-1:0]      Cpu_data2bus,
   output logic [DW-1:0]      Cpu_data4bus,
   output logic               bus_ready,
   output logic               bus_err,
   output logic [NSLV-1:0]    slv_sel,
   output logic               slv_we,
   output logic               slv_rd,
   output logic [DW-1:0]      Peripheral_in,
   output logic [RAM_AW-1:0]  ram_addr,
   input  logic [NSLV*DW-1:0] slv_rdata,
   output logic [7:0]         mode_out,
   output logic               err_flag
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   // Lowest enabled slave whose region matches wins; result is one-hot or zero.
   function automatic logic [NSLV-1:0] decode_region(input logic [3:0] region);
      logic [NSLV-1:0] hit;
      logic            found;
      hit   = {NSLV{1'b0}};
      found = 1'b0;
      for (int i = 0; i < NSLV; i++) begin
         if (!found && SLV_EN[i] && (REGION_MAP[4*i +: 4] == region)) begin
            hit[i] = 1'b1;
            found  = 1'b1;
         end
      end
      return hit;
   endfunction

   // Registered state and outputs
   state_t              state_r;
   logic                req_q_r;
   logic [NSLV-1:0]     slv_sel_r;
   logic                slv_we_r;
   logic                slv_rd_r;
   logic [2:0]          wait_cnt_r;
   logic                wr_r;
   logic [DW-1:0]       rdata_r;
   logic                ready_r;
   logic                err_r;
   logic [DW-1:0]       pdata_r;
   logic [RAM_AW-1:0]   ram_addr_r;
   logic [7:0]          mode_r;
   logic                err_flag_r;
   logic [31:0]         err_addr_r;

   // Next-value signals
   state_t              nxt_state_s;
   logic [NSLV-1:0]     nxt_sel_s;
   logic                nxt_we_s;
   logic                nxt_rd_s;
   logic [2:0]          nxt_cnt_s;
   logic                nxt_wr_s;
   logic [DW-1:0]       nxt_rdata_s;
   logic                nxt_ready_s;
   logic                nxt_err_s;
   logic [DW-1:0]       nxt_pdata_s;
   logic [RAM_AW-1:0]   nxt_raddr_s;
   logic [7:0]          nxt_mode_s;
   logic                nxt_eflag_s;
   logic [31:0]         nxt_eaddr_s;

   // Decode helpers
   logic                start_s;
   logic                ctrl_hit_s;
   logic [NSLV-1:0]     slv_hit_s;
   logic [2:0]          hit_wait_s;
   logic [DW-1:0]       sel_rdata_s;

   assign start_s    = mem_req & ~req_q_r;
   assign ctrl_hit_s = (addr_bus[31:28] == CTRL_REGION);
   assign slv_hit_s  = decode_region(addr_bus[31:28]);

   // Wait count of the decoded slave and read data of the selected slave
   always_comb begin
      sel_rdata_s = {DW{1'b0}};
      hit_wait_s  = 3'd0;
      for (int i = 0; i < NSLV; i++) begin
         sel_rdata_s = sel_rdata_s | (slv_sel_r[i] ? slv_rdata[DW*i +: DW] : {DW{1'b0}});
         hit_wait_s  = hit_wait_s  | (slv_hit_s[i] ? SLV_WAIT[3*i +: 3]    : 3'd0);
      end
   end

   // Access sequencer: next state and next register values
   always_comb begin
      nxt_state_s = state_r;
      nxt_sel_s   = slv_sel_r;
      nxt_we_s    = 1'b0;
      nxt_rd_s    = 1'b0;
      nxt_cnt_s   = wait_cnt_r;
      nxt_wr_s    = wr_r;
      nxt_rdata_s = rdata_r;
      nxt_ready_s = 1'b0;
      nxt_err_s   = 1'b0;
      nxt_pdata_s = pdata_r;
      nxt_raddr_s = ram_addr_r;
      nxt_mode_s  = mode_r;
      nxt_eflag_s = err_flag_r;
      nxt_eaddr_s = err_addr_r;
      case (state_r)
         ST_IDLE: begin
            if (start_s) begin
               nxt_wr_s    = mem_w;
               nxt_pdata_s = Cpu_data2bus;
               nxt_raddr_s = addr_bus[RAM_AW+1:2];
               if (ctrl_hit_s) begin
                  // Control registers answer in the very next cycle
                  nxt_state_s = ST_RESP;
                  nxt_ready_s = 1'b1;
                  case ({addr_bus[2], mem_w})
                     2'b00:   nxt_rdata_s = DW'(mode_r);
                     2'b01: begin
                        nxt_mode_s  = Cpu_data2bus[7:0];
                        nxt_rdata_s = {DW{1'b0}};
                     end
                     2'b10:   nxt_rdata_s = DW'(err_addr_r);
                     2'b11: begin
                        nxt_eflag_s = 1'b0;
                        nxt_rdata_s = {DW{1'b0}};
                     end
                     default: nxt_rdata_s = {DW{1'b0}};
                  endcase
               end else if (|slv_hit_s) begin
                  nxt_state_s = ST_ACCESS;
                  nxt_sel_s   = slv_hit_s;
                  nxt_we_s    = mem_w;
                  nxt_rd_s    = ~mem_w;
                  nxt_cnt_s   = hit_wait_s;
               end else begin
                  // Unmapped: error response and capture of the faulting address
                  nxt_state_s = ST_RESP;
                  nxt_ready_s = 1'b1;
                  nxt_err_s   = 1'b1;
                  nxt_rdata_s = {DW{1'b0}};
                  nxt_eaddr_s = addr_bus;
                  nxt_eflag_s = 1'b1;
               end
            end else begin
               nxt_state_s = ST_IDLE;
            end
         end
         ST_ACCESS: begin
            if (wait_cnt_r == 3'd0) begin
               nxt_state_s = ST_RESP;
               nxt_sel_s   = {NSLV{1'b0}};
               nxt_ready_s = 1'b1;
               nxt_rdata_s = wr_r ? {DW{1'b0}} : sel_rdata_s;
            end else begin
               nxt_cnt_s = wait_cnt_r - 3'd1;
            end
         end
         ST_RESP: begin
            nxt_state_s = ST_IDLE;
         end
         default: begin
            nxt_state_s = ST_IDLE;
            nxt_sel_s   = {NSLV{1'b0}};
         end
      endcase
   end

   // State and output registers; asynchronous reset aborts any access at once
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r    <= ST_IDLE;
         req_q_r    <= 1'b0;
         slv_sel_r  <= {NSLV{1'b0}};
         slv_we_r   <= 1'b0;
         slv_rd_r   <= 1'b0;
         wait_cnt_r <= 3'd0;
         wr_r       <= 1'b0;
         rdata_r    <= {DW{1'b0}};
         ready_r    <= 1'b0;
         err_r      <= 1'b0;
         pdata_r    <= {DW{1'b0}};
         ram_addr_r <= {RAM_AW{1'b0}};
         mode_r     <= 8'h00;
         err_flag_r <= 1'b0;
         err_addr_r <= 32'h0000_0000;
      end else begin
         state_r    <= nxt_state_s;
         req_q_r    <= mem_req;
         slv_sel_r  <= nxt_sel_s;
         slv_we_r   <= nxt_we_s;
         slv_rd_r   <= nxt_rd_s;
         wait_cnt_r <= nxt_cnt_s;
         wr_r       <= nxt_wr_s;
         rdata_r    <= nxt_rdata_s;
         ready_r    <= nxt_ready_s;
         err_r      <= nxt_err_s;
         pdata_r    <= nxt_pdata_s;
         ram_addr_r <= nxt_raddr_s;
         mode_r     <= nxt_mode_s;
         err_flag_r <= nxt_eflag_s;
         err_addr_r <= nxt_eaddr_s;
      end
   end

   assign Cpu_data4bus  = rdata_r;
   assign bus_ready     = ready_r;
   assign bus_err       = err_r;
   assign slv_sel       = slv_sel_r;
   assign slv_we        = slv_we_r;
   assign slv_rd        = slv_rd_r;
   assign Peripheral_in = pdata_r;
   assign ram_addr      = ram_addr_r;
   assign mode_out      = mode_r;
   assign err_flag      = err_flag_r;

endmodule

// File: tb/tb_mio_bus_ctrl.sv
// Testbench for mio_bus_ctrl: directed cases plus randomized accesses
// checked against a transaction-level reference model.
module tb_mio_bus_ctrl;

   localparam int NS  = 8;
   localparam int DWD = 32;

   logic             clk;
   logic             rst;
   logic             mem_req;
   logic             mem_w;
   logic [31:0]      addr_bus;
   logic [31:0]      Cpu_data2bus;
   logic [31:0]      Cpu_data4bus;
   logic             bus_ready;
   logic             bus_err;
   logic [7:0]       slv_sel;
   logic             slv_we;
   logic             slv_rd;
   logic [31:0]      Peripheral_in;
   logic [12:0]      ram_addr;
   logic [NS*DWD-1:0] slv_rdata;
   logic [7:0]       mode_out;
   logic             err_flag;

   int checks   = 0;
   int failures = 0;

   // Slave configuration: region, enable, wait states (index = slave number)
   int map_a [NS] = '{0, 14, 12, 13, 15, 12, 10, 11};
   bit en_a  [NS] = '{1, 1, 1, 1, 1, 1, 0, 1};
   int wait_a[NS] = '{0, 3, 1, 5, 7, 2, 0, 0};
   logic [31:0] rd_a[NS];

   // Reference model state
   logic [7:0]  m_mode;
   logic        m_eflag;
   logic [31:0] m_eaddr;
   logic [31:0] m_data;

   mio_bus_ctrl #(
      .NSLV        (NS),
      .DW          (DWD),
      .RAM_AW      (13),
      .REGION_MAP  ({4'hb, 4'ha, 4'hc, 4'hf, 4'hd, 4'hc, 4'he, 4'h0}),
      .SLV_EN      (8'b1011_1111),
      .SLV_WAIT    ({3'd0, 3'd0, 3'd2, 3'd7, 3'd5, 3'd1, 3'd3, 3'd0}),
      .CTRL_REGION (4'hb)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .mem_req       (mem_req),
      .mem_w         (mem_w),
      .addr_bus      (addr_bus),
      .Cpu_data2bus  (Cpu_data2bus),
      .Cpu_data4bus  (Cpu_data4bus),
      .bus_ready     (bus_ready),
      .bus_err       (bus_err),
      .slv_sel       (slv_sel),
      .slv_we        (slv_we),
      .slv_rd        (slv_rd),
      .Peripheral_in (Peripheral_in),
      .ram_addr      (ram_addr),
      .slv_rdata     (slv_rdata),
      .mode_out      (mode_out),
      .err_flag      (err_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Lowest enabled slave whose region matches, or -1
   function automatic int find_slave(input logic [3:0] region);
      for (int i = 0; i < NS; i++) begin
         if (en_a[i] && (map_a[i] == int'(region))) return i;
      end
      return -1;
   endfunction

   task automatic new_rdata();
      for (int i = 0; i < NS; i++) begin
         rd_a[i] = $urandom;
         slv_rdata[32*i +: 32] = rd_a[i];
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One complete access with cycle-exact checks; ends after one idle cycle with mem_req low
   task automatic run_access(input logic [31:0] a, input logic w, input logic [31:0] d, input bit hold);
      int          idx;
      int          wt;
      bit          is_ctrl;
      logic        exp_err;
      logic [31:0] exp_data;
      logic [7:0]  sel_exp;
      is_ctrl = (a[31:28] == 4'hb);
      idx     = is_ctrl ? -1 : find_slave(a[31:28]);
      addr_bus = a; mem_w = w; Cpu_data2bus = d; mem_req = 1'b1;
      tick();
      check_val("ram_addr", 32'(ram_addr), 32'(a[14:2]));
      check_val("pdata", Peripheral_in, d);
      if (idx < 0) begin
         exp_err = 1'b0;
         if (is_ctrl) begin
            if (!a[2] && w) begin
               m_mode = d[7:0];
               exp_data = 32'd0;
            end else if (!a[2]) begin
               exp_data = {24'h0, m_mode};
            end else if (!w) begin
               exp_data = m_eaddr;
            end else begin
               m_eflag = 1'b0;
               exp_data = 32'd0;
            end
         end else begin
            exp_data = 32'd0;
            exp_err  = 1'b1;
            m_eaddr  = a;
            m_eflag  = 1'b1;
         end
         check_val("short_ready", 32'(bus_ready), 32'd1);
         check_val("short_err", 32'(bus_err), 32'(exp_err));
         check_val("short_data", Cpu_data4bus, exp_data);
         check_val("short_sel", 32'(slv_sel), 32'd0);
         check_val("short_strobe", 32'({slv_we, slv_rd}), 32'd0);
         check_val("mode", 32'(mode_out), 32'(m_mode));
         check_val("eflag", 32'(err_flag), 32'(m_eflag));
      end else begin
         wt = wait_a[idx];
         sel_exp = 8'd1 << idx;
         for (int c = 1; c <= 1 + wt; c++) begin
            if (c > 1) tick();
            check_val("acc_sel", 32'(slv_sel), 32'(sel_exp));
            check_val("acc_we", 32'(slv_we), (c == 1) ? 32'(w) : 32'd0);
            check_val("acc_rd", 32'(slv_rd), (c == 1) ? 32'(!w) : 32'd0);
            check_val("acc_ready", 32'(bus_ready), 32'd0);
            if (!hold) mem_req = 1'b0;
         end
         tick();
         exp_data = w ? 32'd0 : rd_a[idx];
         check_val("resp_ready", 32'(bus_ready), 32'd1);
         check_val("resp_err", 32'(bus_err), 32'd0);
         check_val("resp_data", Cpu_data4bus, exp_data);
         check_val("resp_sel", 32'(slv_sel), 32'd0);
         check_val("resp_strobe", 32'({slv_we, slv_rd}), 32'd0);
      end
      m_data  = exp_data;
      mem_req = 1'b0;
      tick();
      check_val("idle_ready", 32'(bus_ready), 32'd0);
      check_val("idle_data", Cpu_data4bus, m_data);
   endtask

   // Count bus_ready pulses over n cycles while mem_req is manipulated
   task automatic count_ready(input logic [31:0] a, input int n, input int low_c, input int high_c,
                              output int cnt);
      addr_bus = a; mem_w = 1'b0; Cpu_data2bus = 32'd0; mem_req = 1'b1;
      cnt = 0;
      for (int c = 1; c <= n; c++) begin
         tick();
         if (bus_ready) cnt++;
         if (c == low_c)  mem_req = 1'b0;
         if (c == high_c) mem_req = 1'b1;
      end
      mem_req = 1'b0;
      tick();
   endtask

   initial begin
      int cnt;
      logic [31:0] ra;
      rst = 1'b0; mem_req = 1'b0; mem_w = 1'b0;
      addr_bus = 32'd0; Cpu_data2bus = 32'd0; slv_rdata = '0;
      m_mode = 8'h00; m_eflag = 1'b0; m_eaddr = 32'd0; m_data = 32'd0;
      for (int i = 0; i < NS; i++) rd_a[i] = 32'd0;
      #1;
      check_val("rst_ready", 32'(bus_ready), 32'd0);
      check_val("rst_err", 32'(bus_err), 32'd0);
      check_val("rst_sel", 32'(slv_sel), 32'd0);
      check_val("rst_strobe", 32'({slv_we, slv_rd}), 32'd0);
      check_val("rst_data", Cpu_data4bus, 32'd0);
      check_val("rst_pdata", Peripheral_in, 32'd0);
      check_val("rst_raddr", 32'(ram_addr), 32'd0);
      check_val("rst_mode", 32'(mode_out), 32'd0);
      check_val("rst_eflag", 32'(err_flag), 32'd0);
      tick(); tick();
      rst = 1'b1;
      tick();

      // Directed cases
      new_rdata();
      run_access(32'h0000_0010, 1'b1, 32'hDEAD_BEEF, 1'b0);
      rd_a[1] = 32'h1234_5678; slv_rdata[32 +: 32] = rd_a[1];
      run_access(32'hE000_0000, 1'b0, 32'h0, 1'b0);
      run_access(32'h5000_0000, 1'b0, 32'h0, 1'b0);
      run_access(32'hB000_0004, 1'b0, 32'h0, 1'b0);
      check_val("err_addr_rd", Cpu_data4bus, 32'h5000_0000);
      run_access(32'hB000_0004, 1'b1, 32'hFFFF_FFFF, 1'b0);
      run_access(32'hB000_0000, 1'b1, 32'h0000_00A5, 1'b0);
      check_val("mode_a5", 32'(mode_out), 32'h0000_00A5);
      run_access(32'hB000_0000, 1'b0, 32'h0, 1'b1);
      check_val("mode_rd", Cpu_data4bus, 32'h0000_00A5);
      run_access(32'hC000_0040, 1'b0, 32'h0, 1'b0);
      run_access(32'hA000_0000, 1'b0, 32'h0, 1'b0);
      run_access(32'hD000_1234, 1'b1, 32'h0BAD_F00D, 1'b1);

      // mem_req held high: exactly one completion
      count_ready(32'h0000_0020, 10, 0, 0, cnt);
      check_val("held_cnt", 32'(cnt), 32'd1);
      m_data = rd_a[0];
      // Rising edge during ACCESS is not queued
      count_ready(32'hF000_0000, 14, 2, 3, cnt);
      check_val("toggle_cnt", 32'(cnt), 32'd1);
      m_data = rd_a[4];

      // Reset in cycle 2 of a W=5 read
      run_access(32'h7000_0008, 1'b0, 32'h0, 1'b0);
      addr_bus = 32'hD000_0000; mem_w = 1'b0; mem_req = 1'b1;
      tick();
      check_val("pre_rst_sel", 32'(slv_sel), 32'h08);
      tick();
      rst = 1'b0; mem_req = 1'b0;
      #1;
      check_val("abort_sel", 32'(slv_sel), 32'd0);
      check_val("abort_outs", 32'({bus_ready, bus_err, slv_we, slv_rd, err_flag}), 32'd0);
      check_val("abort_mode", 32'(mode_out), 32'd0);
      check_val("abort_data", Cpu_data4bus | Peripheral_in | 32'(ram_addr), 32'd0);
      m_mode = 8'h00; m_eflag = 1'b0; m_eaddr = 32'd0; m_data = 32'd0;
      tick();
      rst = 1'b1;
      cnt = 0;
      for (int c = 0; c < 8; c++) begin
         tick();
         if (bus_ready || (slv_sel != 8'd0)) cnt++;
      end
      check_val("post_abort", 32'(cnt), 32'd0);
      run_access(32'hB000_0004, 1'b0, 32'h0, 1'b0);

      // Randomized accesses
      for (int t = 0; t < 150; t++) begin
         new_rdata();
         ra = {4'($urandom_range(0, 15)), 28'($urandom)};
         run_access(ra, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
